ibex_hpm_counter_bank: RTL and testbench
========================================

# ibex_hpm_counter_bank

Parametrised bank of RISC-V hardware performance monitor counters (mhpmcounter3..N, mhpmcounterNh, mhpmevent3..N, and the matching mcountinhibit bits), instantiated alongside the CS register file. Each counter counts cycles in which any of its selected events is asserted. Counters are generalised in count and width, with per-counter event masks, inhibit, and split 32-bit low/high CSR access. An optional overflow interrupt can be compiled in.

## Interface
- NumCounters, 8: implemented counters, 0..29; counter k maps to index 3+k.
- CounterWidth, 40: implemented bits per counter, 1..64; bits above read 0.
- NumEvents, 16: event inputs, 1..32; width of each mhpmevent mask.
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  asynchronous, active-low reset.
- csr_addr_i  in  12  CSR address of the current access.
- csr_we_i  in  1  write strobe; the write takes effect on the next rising edge.
- csr_wdata_i  in  32  write data, already resolved for set/clear by the CSR block.
- csr_rdata_o  out  32  combinational read data for csr_addr_i.
- csr_hit_o  out  1  csr_addr_i falls inside this block's address ranges.
- event_i  in  NumEvents  single-cycle event strobes from the core.
- stop_count_i  in  1  freeze all counters (debug mode with dcsr.stopcount set).
- irq_overflow_o  out  1  counter-overflow interrupt request; see Configuration.

## Operation
- Address ranges (csr_hit_o=1):
  - 0xB03-0xB1F: low halves.
  - 0xB83-0xB9F: high halves.
  - 0x323-0x33F: mhpmevent.
  - 0x320: mcountinhibit.
- Indices at or above 3+NumCounters are hardwired zero: they read 0, writes are ignored, and csr_hit_o still asserts.
- mcountinhibit: the block owns bits [3+NumCounters-1:3] and returns zero in all other bits. The CSR block ORs in the cycle/instret bits.
- mhpmevent k: bits [NumEvents-1:0] are writable; upper bits read 0.
- Increment condition for counter k:
  - (mhpmevent[k] & event_i) != 0,
  - and inhibit[k]=0,
  - and stop_count_i=0.
- Increment is +1 per cycle, regardless of how many selected events fire.
- Arithmetic is modulo 2^CounterWidth: all-ones wraps to 0.
- Low write: sets bits [min(31,CW-1):0] and keeps the upper bits.
- High write: sets bits [CW-1:32] and keeps the low 32 bits. It is ignored when CW<=32, and the high half then reads 0.
- Write vs. increment: a CSR write to counter k in the same cycle as an increment wins. The increment is dropped, and the written value appears unmodified.
- A write to one half never carries into or out of the other half.
- Reset clears all counters, mhpmevent masks, inhibit bits and overflow state. irq_overflow_o=0, csr_rdata_o=0 for any in-range address after reset.

## Timing
- Read: combinational, zero latency. It returns the register value before this cycle's update.
- Increment: an event at edge n is visible on reads from cycle n+1.
- Write: visible on reads in the cycle after csr_we_i.
- Inhibit: a write to mcountinhibit affects counting from the following cycle. An event in the write cycle counts under the old inhibit value.
- stop_count_i: takes effect combinationally in the same cycle.
- Reset: asserting rst_ni mid-count clears state immediately (asynchronous). Counting resumes on the first edge after deassertion.

## Configuration
- IBEX_HPM_OVERFLOW_IRQ_EN defined:
  - Each counter gets a sticky overflow flag, set on the edge where the counter wraps all-ones -> 0.
  - A CSR write to either half of that counter clears its flag; the clear wins over a simultaneous set.
  - irq_overflow_o is the registered OR of all flags and asserts one cycle after the wrap edge.
- Undefined: no flags are instantiated and irq_overflow_o is tied to 0.

## Structure
- Package ibex_pkg gains:
  - CSR_OFF_MHPMEVENT (0x320);
  - CSR_MHPM_FIRST_IDX (3);
  - CSR_MHPM_MAX_COUNTERS (29);
  - an hpm_sel_e enum for the decoded region {HPM_SEL_NONE, HPM_SEL_LO, HPM_SEL_HI, HPM_SEL_EVENT, HPM_SEL_INHIBIT}.
- Reuse the existing CSR_OFF_MCOUNTER, CSR_OFF_MCOUNTERH and CSR_MASK_MCOUNTER.
- Sub-module ibex_hpm_counter: one counter register (parametrised by CounterWidth) holding increment, half-writes and the optional overflow flag. It is generated NumCounters times. The top level holds the decode, the mhpmevent and inhibit registers, and the read mux.

## Test plan
- Reset, then read 0xB03, 0xB83, 0x323 and 0x320 -> all 0; csr_hit_o=1; irq_overflow_o=0.
- mhpmevent3=0x5, pulse event_i bits 0 and 2 together for 1 cycle, then bit 2 alone for 3 cycles -> mhpmcounter3 reads 4.
- CW=40: write 0xB83=0xFF, then 0xB03=0xFFFFFFFF, then one event -> low reads 0 and high reads 0. With the macro on, irq_overflow_o=1 one cycle after the wrap, and a write to 0xB03 clears it.
- Same-cycle write 0x1234 to 0xB04 while counter 4's event fires -> reads 0x1234, not 0x1235.
- Set mcountinhibit bit 3 while events run -> counter 3 is frozen and counter 4 keeps counting. Holding stop_count_i=1 freezes both.
- NumCounters=2: read 0xB05 -> 0 with csr_hit_o=1; a write to it has no effect. Read 0x7B0 -> csr_hit_o=0.

Source files
------------

// File: rtl/ibex_pkg.sv
// CSR address constants and HPM region decode shared by the performance counter bank.
// Pure declarations: no state, no timing.
package ibex_pkg;

  localparam logic [11:0] CSR_OFF_MCOUNTER  = 12'hB00;
  localparam logic [11:0] CSR_OFF_MCOUNTERH = 12'hB80;
  localparam logic [11:0] CSR_MASK_MCOUNTER = 12'hFE0;
  localparam logic [11:0] CSR_OFF_MHPMEVENT = 12'h320;

  localparam int unsigned CSR_MHPM_FIRST_IDX    = 3;
  localparam int unsigned CSR_MHPM_MAX_COUNTERS = 29;

  typedef enum logic [2:0] {
    HPM_SEL_NONE,
    HPM_SEL_LO,
    HPM_SEL_HI,
    HPM_SEL_EVENT,
    HPM_SEL_INHIBIT
  } hpm_sel_e;

  // Indices 0..2 of each 32-entry window belong to cycle/time/instret and are not ours.
  function automatic hpm_sel_e hpm_decode(input logic [11:0] addr);
    hpm_sel_e sel;
    logic     idx_ok;
    idx_ok = addr[4:0] >= 5'(CSR_MHPM_FIRST_IDX);
    sel    = HPM_SEL_NONE;
    if (addr == CSR_OFF_MHPMEVENT) begin
      sel = HPM_SEL_INHIBIT;
    end else if (idx_ok) begin
      if ((addr & CSR_MASK_MCOUNTER) == CSR_OFF_MCOUNTER) begin
        sel = HPM_SEL_LO;
      end else if ((addr & CSR_MASK_MCOUNTER) == CSR_OFF_MCOUNTERH) begin
        sel = HPM_SEL_HI;
      end else if ((addr & CSR_MASK_MCOUNTER) == CSR_OFF_MHPMEVENT) begin
        sel = HPM_SEL_EVENT;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ibex_hpm_counter.sv
// One HPM counter with split 32-bit half writes; updates one cycle after inc/write, no backpressure.
// Optional sticky wrap flag under IBEX_HPM_OVERFLOW_IRQ_EN.
module ibex_hpm_counter
  import ibex_pkg::*;
#(
  parameter int unsigned CounterWidth = 40
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
`ifdef IBEX_HPM_OVERFLOW_IRQ_EN
  ,
  output logic        overflow_o
`endif
);

  logic [CounterWidth-1:0] cnt_q, cnt_d;
  logic                    wr;
  logic                    wrap;

  assign wr = we_lo_i | we_hi_i;

  // A write lands unmodified and suppresses the increment, so halves never carry into each other.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = 1'b0;
    if (wr) begin
      for (int b = 0; b < int'(CounterWidth); b++) begin
        if (b < 32) begin
          if (we_lo_i) cnt_d[b] = wdata_i[b % 32];
        end else begin
          if (we_hi_i) cnt_d[b] = wdata_i[b % 32];
        end
      end
    end else if (inc_i) begin
      cnt_d = cnt_q + CounterWidth'(1);
      wrap  = &cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value_o = 64'(cnt_q);

`ifdef IBEX_HPM_OVERFLOW_IRQ_EN
  logic ovf_q, ovf_d;

  assign ovf_d = wr ? 1'b0 : (ovf_q | wrap);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
`endif

endmodule

// File: rtl/ibex_hpm_counter_bank.sv
// Bank of mhpmcounter/mhpmevent/mcountinhibit CSRs; reads combinational, writes/counts land next edge.
// No backpressure; overflow IRQ compiled in with IBEX_HPM_OVERFLOW_IRQ_EN (registered, +1 cycle).
module ibex_hpm_counter_bank
  import ibex_pkg::*;
#(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 40,
  parameter int unsigned NumEvents    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [11:0]          csr_addr_i,
  input  logic                 csr_we_i,
  input  logic [31:0]          csr_wdata_i,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_hit_o,
  input  logic [NumEvents-1:0] event_i,
  input  logic                 stop_count_i,
  output logic                 irq_overflow_o
);

  localparam int unsigned NumCntClamp =
      (NumCounters > CSR_MHPM_MAX_COUNTERS) ? CSR_MHPM_MAX_COUNTERS : NumCounters;
  localparam int unsigned NumCntImpl  = (NumCntClamp > 0) ? NumCntClamp : 1;
  localparam bit          CntPresent  = NumCntClamp > 0;

  hpm_sel_e              sel;
  logic [4:0]            idx;
  logic [NumEvents-1:0]  mhpmevent_q [NumCntImpl];
  logic [NumEvents-1:0]  mhpmevent_d [NumCntImpl];
  logic [NumCntImpl-1:0] inhibit_q, inhibit_d;
  logic [NumCntImpl-1:0] addr_match, inc, we_lo, we_hi;
  logic [63:0]           cnt_val [NumCntImpl];

  assign sel       = hpm_decode(csr_addr_i);
  assign idx       = csr_addr_i[4:0];
  assign csr_hit_o = (sel != HPM_SEL_NONE);

`ifdef IBEX_HPM_OVERFLOW_IRQ_EN
  logic [NumCntImpl-1:0] ovf;
`endif

  for (genvar k = 0; k < int'(NumCntImpl); k++) begin : g_cnt
    assign addr_match[k] = CntPresent && (idx == 5'(k + CSR_MHPM_FIRST_IDX));
    assign inc[k]   = (|(mhpmevent_q[k] & event_i)) & ~inhibit_q[k] & ~stop_count_i;
    assign we_lo[k] = csr_we_i & addr_match[k] & (sel == HPM_SEL_LO);
    assign we_hi[k] = csr_we_i & addr_match[k] & (sel == HPM_SEL_HI);

    ibex_hpm_counter #(
      .CounterWidth (CounterWidth)
    ) u_counter (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (inc[k]),
      .we_lo_i    (we_lo[k]),
      .we_hi_i    (we_hi[k]),
      .wdata_i    (csr_wdata_i),
      .value_o    (cnt_val[k])
`ifdef IBEX_HPM_OVERFLOW_IRQ_EN
      ,
      .overflow_o (ovf[k])
`endif
    );
  end

  always_comb begin
    inhibit_d = inhibit_q;
    if (csr_we_i && (sel == HPM_SEL_INHIBIT)) begin
      inhibit_d = CntPresent ?
          csr_wdata_i[CSR_MHPM_FIRST_IDX+NumCntImpl-1:CSR_MHPM_FIRST_IDX] : '0;
    end
    for (int i = 0; i < int'(NumCntImpl); i++) begin
      mhpmevent_d[i] = mhpmevent_q[i];
      if (csr_we_i && (sel == HPM_SEL_EVENT) && addr_match[i]) begin
        mhpmevent_d[i] = csr_wdata_i[NumEvents-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inhibit_q <= '0;
      for (int i = 0; i < int'(NumCntImpl); i++) mhpmevent_q[i] <= '0;
    end else begin
      inhibit_q <= inhibit_d;
      for (int i = 0; i < int'(NumCntImpl); i++) mhpmevent_q[i] <= mhpmevent_d[i];
    end
  end

  // Unimplemented indices match nothing and so read as zero while still hitting.
  always_comb begin
    csr_rdata_o = '0;
    for (int i = 0; i < int'(NumCntImpl); i++) begin
      if (addr_match[i]) begin
        case (sel)
          HPM_SEL_LO:    csr_rdata_o = cnt_val[i][31:0];
          HPM_SEL_HI:    csr_rdata_o = cnt_val[i][63:32];
          HPM_SEL_EVENT: csr_rdata_o = 32'(mhpmevent_q[i]);
          default:       ;
        endcase
      end
    end
    if (sel == HPM_SEL_INHIBIT) csr_rdata_o = 32'({inhibit_q, 3'b000});
  end

`ifdef IBEX_HPM_OVERFLOW_IRQ_EN
  logic irq_q, irq_d;

  assign irq_d = |ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_overflow_o = irq_q;
`else
  assign irq_overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_hpm_counter_bank.sv
// Randomized and directed checks of the HPM counter bank against an arithmetic reference model.
module tb_ibex_hpm_counter_bank;

  localparam int NC = 8;
  localparam int CW = 40;
  localparam int NE = 16;

  localparam logic [63:0] WMASK = (CW >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CW) - 64'd1);
  localparam logic [31:0] EMASK = (NE >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NE) - 32'd1);
  localparam logic [31:0] IMASK = ((32'd1 << NC) - 32'd1) << 3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [11:0]   csr_addr_i;
  logic          csr_we_i;
  logic [31:0]   csr_wdata_i;
  logic [31:0]   csr_rdata_o;
  logic          csr_hit_o;
  logic [NE-1:0] event_i;
  logic          stop_count_i;
  logic          irq_overflow_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  ibex_hpm_counter_bank #(
    .NumCounters  (NC),
    .CounterWidth (CW),
    .NumEvents    (NE)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .csr_addr_i     (csr_addr_i),
    .csr_we_i       (csr_we_i),
    .csr_wdata_i    (csr_wdata_i),
    .csr_rdata_o    (csr_rdata_o),
    .csr_hit_o      (csr_hit_o),
    .event_i        (event_i),
    .stop_count_i   (stop_count_i),
    .irq_overflow_o (irq_overflow_o)
  );

  // Reference model: counters as plain integers, masks and inhibit as words.
  logic [63:0] m_cnt  [32];
  logic [31:0] m_mask [32];
  logic [31:0] m_inh;
  logic [31:0] m_ovf;
  logic        m_irq;

  function automatic logic [11:0] a_lo(input int k);  return 12'(32'hB03 + k); endfunction
  function automatic logic [11:0] a_hi(input int k);  return 12'(32'hB83 + k); endfunction
  function automatic logic [11:0] a_ev(input int k);  return 12'(32'h323 + k); endfunction

  function automatic bit wr_lo(input int k);  return csr_we_i && (csr_addr_i == a_lo(k)); endfunction
  function automatic bit wr_hi(input int k);  return csr_we_i && (csr_addr_i == a_hi(k)); endfunction
  function automatic bit counts(input int k);
    return ((m_mask[k] & 32'(event_i)) != 0) && !m_inh[k+3] && !stop_count_i;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 32; k++) begin
        m_cnt[k]  <= '0;
        m_mask[k] <= '0;
      end
      m_inh <= '0;
      m_ovf <= '0;
      m_irq <= 1'b0;
    end else begin
      m_irq <= (m_ovf != 0);
      for (int k = 0; k < NC; k++) begin
        if (wr_lo(k))       m_cnt[k] <= {m_cnt[k][63:32], csr_wdata_i} & WMASK;
        else if (wr_hi(k))  m_cnt[k] <= (CW > 32) ? ({csr_wdata_i, m_cnt[k][31:0]} & WMASK) : m_cnt[k];
        else if (counts(k)) m_cnt[k] <= (m_cnt[k] + 64'd1) & WMASK;
        if (wr_lo(k) || wr_hi(k))                  m_ovf[k] <= 1'b0;
        else if (counts(k) && (m_cnt[k] == WMASK)) m_ovf[k] <= 1'b1;
        if (csr_we_i && (csr_addr_i == a_ev(k)))   m_mask[k] <= csr_wdata_i & EMASK;
      end
      if (csr_we_i && (csr_addr_i == 12'h320)) m_inh <= csr_wdata_i & IMASK;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [11:0] a);
    int i;
    exp_rd = '0;
    if (a >= 12'hB03 && a <= 12'hB1F) begin
      i = int'(a) - 32'hB03;
      if (i < NC) exp_rd = m_cnt[i][31:0];
    end else if (a >= 12'hB83 && a <= 12'hB9F) begin
      i = int'(a) - 32'hB83;
      if (i < NC) exp_rd = m_cnt[i][63:32];
    end else if (a >= 12'h323 && a <= 12'h33F) begin
      i = int'(a) - 32'h323;
      if (i < NC) exp_rd = m_mask[i];
    end else if (a == 12'h320) begin
      exp_rd = m_inh;
    end
  endfunction

  function automatic bit exp_hit(input logic [11:0] a);
    return (a >= 12'hB03 && a <= 12'hB1F) || (a >= 12'hB83 && a <= 12'hB9F) ||
           (a >= 12'h323 && a <= 12'h33F) || (a == 12'h320);
  endfunction

  // Each call applies its inputs to exactly one rising edge.
  task automatic drive(input logic we, input logic [11:0] a, input logic [31:0] d,
                       input logic [NE-1:0] ev, input logic stop);
    @(posedge clk_i);
    #1;
    csr_we_i     = we;
    csr_addr_i   = a;
    csr_wdata_i  = d;
    event_i      = ev;
    stop_count_i = stop;
  endtask

  task automatic rd(input logic [11:0] a);
    drive(1'b0, a, 32'h0, '0, 1'b0);
    #1;
  endtask

  task automatic test_reset;
    logic [11:0] addrs [4];
    addrs = '{12'hB03, 12'hB83, 12'h323, 12'h320};
    rst_ni = 1'b0;
    drive(1'b0, 12'hB03, 32'h0, '0, 1'b0);
    drive(1'b0, 12'hB03, 32'h0, '0, 1'b0);
    #2 rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(addrs[i]);
      checks++;
      if (csr_rdata_o !== 32'h0 || csr_hit_o !== 1'b1) begin
        errors++;
        $display("FAIL reset_read addr=%h: got rdata=%h hit=%b, expected 0 hit=1", addrs[i], csr_rdata_o, csr_hit_o);
      end
    end
    checks++;
    if (irq_overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", irq_overflow_o);
    end
  endtask

  task automatic test_event_count;
    drive(1'b1, 12'h323, 32'h5, '0, 1'b0);
    drive(1'b0, 12'hB03, 32'h0, 16'h0005, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 12'hB03, 32'h0, 16'h0004, 1'b0);
    rd(12'hB03);
    checks++;
    if (csr_rdata_o !== 32'd4) begin
      errors++;
      $display("FAIL event_count: got %0d expected 4", csr_rdata_o);
    end
    rd(12'h323);
    checks++;
    if (csr_rdata_o !== 32'h5) begin
      errors++;
      $display("FAIL event_mask_read: got %h expected 5", csr_rdata_o);
    end
  endtask

  task automatic test_wrap;
    drive(1'b1, 12'hB83, 32'hFF, '0, 1'b0);
    drive(1'b1, 12'hB03, 32'hFFFF_FFFF, '0, 1'b0);
    rd(12'hB83);
    checks++;
    if (csr_rdata_o !== 32'hFF) begin
      errors++;
      $display("FAIL high_write: got %h expected ff", csr_rdata_o);
    end
    drive(1'b0, 12'hB03, 32'h0, 16'h0001, 1'b0);
    rd(12'hB03);
    checks++;
    if (csr_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_low: got %h expected 0", csr_rdata_o);
    end
    rd(12'hB83);
    checks++;
    if (csr_rdata_o !== 32'h0) begin
      errors++;
      $display("FAIL wrap_high: got %h expected 0", csr_rdata_o);
    end
`ifdef IBEX_HPM_OVERFLOW_IRQ_EN
    checks++;
    if (irq_overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL wrap_irq: got %b expected 1", irq_overflow_o);
    end
    drive(1'b1, 12'hB03, 32'h0, '0, 1'b0);
    rd(12'hB03);
    rd(12'hB03);
    checks++;
    if (irq_overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: got %b expected 0", irq_overflow_o);
    end
`else
    checks++;
    if (irq_overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL irq_tied: got %b expected 0", irq_overflow_o);
    end
`endif
  endtask

  task automatic test_write_wins;
    drive(1'b1, 12'h324, 32'h1, '0, 1'b0);
    drive(1'b1, 12'hB04, 32'h1234, 16'h0001, 1'b0);
    rd(12'hB04);
    checks++;
    if (csr_rdata_o !== 32'h1234) begin
      errors++;
      $display("FAIL write_wins: got %h expected 1234", csr_rdata_o);
    end
  endtask

  task automatic test_inhibit;
    logic [31:0] c3, c4;
    rd(12'hB03);
    c3 = csr_rdata_o;
    // The event in the inhibit-write cycle still counts for counter 3.
    drive(1'b1, 12'h320, 32'h8, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 12'hB03, 32'h0, 16'h0001, 1'b0);
    rd(12'hB03);
    checks++;
    if (csr_rdata_o !== c3 + 32'd1) begin
      errors++;
      $display("FAIL inhibit_frozen: got %h expected %h", csr_rdata_o, c3 + 32'd1);
    end
    rd(12'hB04);
    checks++;
    if (csr_rdata_o !== 32'h1239) begin
      errors++;
      $display("FAIL inhibit_other_counts: got %h expected 1239", csr_rdata_o);
    end
    rd(12'h320);
    checks++;
    if (csr_rdata_o !== 32'h8) begin
      errors++;
      $display("FAIL inhibit_read: got %h expected 8", csr_rdata_o);
    end
    drive(1'b1, 12'h320, 32'hFFFF_FFFF, '0, 1'b0);
    rd(12'h320);
    checks++;
    if (csr_rdata_o !== 32'h0000_07F8) begin
      errors++;
      $display("FAIL inhibit_owned_bits: got %h expected 7f8", csr_rdata_o);
    end
    drive(1'b1, 12'h320, 32'h0, '0, 1'b0);
    rd(12'hB03);
    c3 = csr_rdata_o;
    rd(12'hB04);
    c4 = csr_rdata_o;
    for (int i = 0; i < 3; i++) drive(1'b0, 12'hB03, 32'h0, 16'h0005, 1'b1);
    rd(12'hB03);
    checks++;
    if (csr_rdata_o !== c3) begin
      errors++;
      $display("FAIL stop_count_c3: got %h expected %h", csr_rdata_o, c3);
    end
    rd(12'hB04);
    checks++;
    if (csr_rdata_o !== c4) begin
      errors++;
      $display("FAIL stop_count_c4: got %h expected %h", csr_rdata_o, c4);
    end
  endtask

  task automatic test_out_of_range;
    logic [11:0] hit_addrs [5];
    logic [11:0] miss_addrs [5];
    hit_addrs  = '{12'hB0B, 12'hB8B, 12'h32B, 12'hB1F, 12'hB9F};
    miss_addrs = '{12'h7B0, 12'hB00, 12'hB02, 12'h321, 12'hBA0};
    drive(1'b1, 12'hB0B, 32'hDEAD_BEEF, '0, 1'b0);
    drive(1'b1, 12'h32B, 32'hFFFF_FFFF, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rd(hit_addrs[i]);
      checks++;
      if (csr_rdata_o !== 32'h0 || csr_hit_o !== 1'b1) begin
        errors++;
        $display("FAIL unimpl_idx addr=%h: got rdata=%h hit=%b, expected 0 hit=1", hit_addrs[i], csr_rdata_o, csr_hit_o);
      end
      rd(miss_addrs[i]);
      checks++;
      if (csr_hit_o !== 1'b0 || csr_rdata_o !== 32'h0) begin
        errors++;
        $display("FAIL miss addr=%h: got hit=%b rdata=%h, expected hit=0 rdata=0", miss_addrs[i], csr_hit_o, csr_rdata_o);
      end
    end
  endtask

  task automatic test_random;
    logic [11:0]   a;
    logic [31:0]   d;
    logic [NE-1:0] ev;
    logic          we, stop;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: a = 12'(32'hB00 + $urandom_range(3, 31));
        1: a = 12'(32'hB80 + $urandom_range(3, 31));
        2: a = 12'(32'h320 + $urandom_range(3, 31));
        3: a = 12'h320;
        default: a = 12'($urandom);
      endcase
      we   = ($urandom_range(0, 9) < 3);
      d    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      ev   = NE'($urandom);
      stop = ($urandom_range(0, 9) == 0);
      drive(we, a, d, ev, stop);
      #1;
      checks++;
      if (csr_rdata_o !== exp_rd(a) || csr_hit_o !== exp_hit(a)) begin
        errors++;
        $display("FAIL random_read addr=%h: got rdata=%h hit=%b, expected rdata=%h hit=%b",
                 a, csr_rdata_o, csr_hit_o, exp_rd(a), exp_hit(a));
      end
`ifdef IBEX_HPM_OVERFLOW_IRQ_EN
      checks++;
      if (irq_overflow_o !== m_irq) begin
        errors++;
        $display("FAIL random_irq: got %b expected %b", irq_overflow_o, m_irq);
      end
`endif
    end
    for (int k = 0; k < NC; k++) begin
      rd(a_lo(k));
      checks++;
      if (csr_rdata_o !== m_cnt[k][31:0]) begin
        errors++;
        $display("FAIL random_final_lo k=%0d: got %h expected %h", k, csr_rdata_o, m_cnt[k][31:0]);
      end
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 12'h324, 32'h1, '0, 1'b0);
    drive(1'b1, 12'hB04, 32'h10, '0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 12'hB04, 32'h0, 16'h0001, 1'b0);
    #3 rst_ni = 1'b0;
    #1;
    checks++;
    if (csr_rdata_o !== 32'h0 || irq_overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got rdata=%h irq=%b, expected 0 0", csr_rdata_o, irq_overflow_o);
    end
    event_i = '0;
    #2 rst_ni = 1'b1;
    drive(1'b1, 12'h324, 32'h1, '0, 1'b0);
    drive(1'b0, 12'hB04, 32'h0, 16'h0001, 1'b0);
    rd(12'hB04);
    checks++;
    if (csr_rdata_o !== 32'h1) begin
      errors++;
      $display("FAIL count_after_reset: got %h expected 1", csr_rdata_o);
    end
  endtask

  initial begin
    csr_addr_i   = 12'hB03;
    csr_we_i     = 1'b0;
    csr_wdata_i  = 32'h0;
    event_i      = '0;
    stop_count_i = 1'b0;
    rst_ni       = 1'b0;
    test_reset();
    test_event_count();
    test_wrap();
    test_write_wins();
    test_inhibit();
    test_out_of_range();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
